// File: rtl/n8_ctrl_reader_if.sv
// rtl/n8_ctrl_reader_if.sv - controller serial link and decoded button bus
// master: the reader (drives strobes/buttons); slave: controller side / observer.
interface n8_ctrl_reader_if;
  logic ctrl_data;
  logic ctrl_latch;
  logic ctrl_pulse;
  logic a;
  logic b;
  logic select;
  logic start;
  logic up;
  logic down;
  logic left;
  logic right;
  logic valid;

  modport master (
    input  ctrl_data,
    output ctrl_latch, ctrl_pulse,
    output a, b, select, start, up, down, left, right,
    output valid
  );

  modport slave (
    output ctrl_data,
    input  ctrl_latch, ctrl_pulse,
    input  a, b, select, start, up, down, left, right,
    input  valid
  );
endinterface

// File: rtl/n8_ctrl_reader.sv
// rtl/n8_ctrl_reader.sv - 8-button serial game controller poller
// Optional N8_CTRL_DEBOUNCE_EN: outputs update only when two consecutive frames agree.
module n8_ctrl_reader #(
  parameter int HALF     = 300,
  parameter int POLL_GAP = 800000
) (
  input  logic               clk,
  input  logic               reset,
  n8_ctrl_reader_if.master   bus
);

  localparam int MAXC = (2 * HALF > POLL_GAP) ? 2 * HALF : POLL_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(POLL_GAP - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_HI, SHIFT_LO, UPDATE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    btn;
  logic          latch_q, pulse_q, valid_q;
`ifdef N8_CTRL_DEBOUNCE_EN
  logic [7:0]    prev_raw;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    shift_nx = shift;
    case (state)
      IDLE: begin
        if (cnt == IDLE_LAST) begin
          state_nx = LATCH;
          cnt_nx   = '0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          shift_nx[0] = bus.ctrl_data;
          idx_nx      = 3'd1;
          state_nx    = SHIFT_HI;
          cnt_nx      = '0;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          state_nx = SHIFT_LO;
          cnt_nx   = '0;
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          shift_nx[idx] = bus.ctrl_data;
          cnt_nx        = '0;
          if (idx == 3'd7) begin
            state_nx = UPDATE;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = SHIFT_HI;
          end
        end
      end
      UPDATE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they track the FSM without decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      btn     <= '0;
`ifdef N8_CTRL_DEBOUNCE_EN
      prev_raw <= 8'hFF;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      shift   <= shift_nx;
      latch_q <= (state_nx == LATCH);
      pulse_q <= (state_nx == SHIFT_HI);
      valid_q <= (state_nx == UPDATE);
      if (state == UPDATE) begin
`ifdef N8_CTRL_DEBOUNCE_EN
        if (shift == prev_raw) btn <= ~shift;
        prev_raw <= shift;
`else
        btn <= ~shift;
`endif
      end
    end
  end

  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_pulse = pulse_q;
  assign bus.valid      = valid_q;
  assign bus.a          = btn[0];
  assign bus.b          = btn[1];
  assign bus.select     = btn[2];
  assign bus.start      = btn[3];
  assign bus.up         = btn[4];
  assign bus.down       = btn[5];
  assign bus.left       = btn[6];
  assign bus.right      = btn[7];

endmodule
